// File: rtl/charmap_dma_if.sv
// charmap_dma_if: CPU access bus plus the CPU-side port of the chmap/fgcol/bgcol RAMs.
// master = the sequencer (owns the RAM port); slave = the CPU decode / RAM side.
interface charmap_dma_if;
   logic        cpu_req;
   logic [2:0]  cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic [11:0] ram_addr;
   logic [2:0]  ram_we;
   logic [7:0]  ram_din_ch;
   logic [7:0]  ram_din_fg;
   logic [7:0]  ram_din_bg;
   logic [7:0]  ram_dout_ch;
   logic [7:0]  ram_dout_fg;
   logic [7:0]  ram_dout_bg;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      input  ram_dout_ch, ram_dout_fg, ram_dout_bg,
      output ram_addr, ram_we, ram_din_ch, ram_din_fg, ram_din_bg
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      output ram_dout_ch, ram_dout_fg, ram_dout_bg,
      input  ram_addr, ram_we, ram_din_ch, ram_din_fg, ram_din_bg
   );
endinterface

// File: rtl/charmap_dma.sv
// charmap_dma: owns the CPU-side char-RAM port; performs screen fill and one-row scroll-up.
// Scroll mode is built only when CHARMAP_DMA_SCROLL_EN is defined; otherwise every command fills.
module charmap_dma #(
   parameter int COLS = 40,
   parameter int ROWS = 30
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_start,
   input  logic         cmd_scroll,
   input  logic [7:0]   fill_ch,
   input  logic [7:0]   fill_fg,
   input  logic [7:0]   fill_bg,
   output logic         busy,
   output logic         done,
   charmap_dma_if.master bus
);
   localparam logic [5:0] X_LAST = 6'(COLS - 1);
   localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

`ifdef CHARMAP_DMA_SCROLL_EN
   localparam logic [5:0] Y_SCR_LAST = 6'(ROWS - 2);
   typedef enum logic [2:0] {IDLE, FILL, SCR_RD, SCR_CAP, SCR_WR, SCR_FILL, FIN} state_t;
`else
   typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;
`endif

   state_t      state, state_nxt;
   logic [5:0]  x, y, x_nxt, y_nxt;
   logic [5:0]  x_adv, y_adv, y_src;
   logic        row_end;
   logic        stall;
   logic        accept;
   logic [7:0]  fch, ffg, fbg;
   logic [11:0] eng_addr;
   logic [2:0]  eng_we;
   logic [7:0]  eng_ch, eng_fg, eng_bg;

   assign stall   = bus.cpu_req;
   assign accept  = cmd_start && (state == IDLE);
   assign row_end = (x == X_LAST);
   assign x_adv   = row_end ? 6'd0 : x + 6'd1;
   assign y_adv   = row_end ? y + 6'd1 : y;
   assign y_src   = y + 6'd1;

   assign busy = (state != IDLE) && (state != FIN);
   assign done = (state == FIN);

`ifdef CHARMAP_DMA_SCROLL_EN
   logic [7:0] hold_ch, hold_fg, hold_bg;

   // RAM read data is valid in SCR_CAP regardless of who owns the port this cycle
   always_ff @(posedge clk) begin
      if (state == SCR_CAP) begin
         hold_ch <= bus.ram_dout_ch;
         hold_fg <= bus.ram_dout_fg;
         hold_bg <= bus.ram_dout_bg;
      end
   end
`else
   logic unused_scroll_in;
   assign unused_scroll_in = ^{cmd_scroll, bus.ram_dout_ch, bus.ram_dout_fg, bus.ram_dout_bg};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         x     <= 6'd0;
         y     <= 6'd0;
      end else begin
         state <= state_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fch <= fill_ch;
         ffg <= fill_fg;
         fbg <= fill_bg;
      end
   end

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      eng_addr  = {y, x};
      eng_we    = 3'b000;
      eng_ch    = fch;
      eng_fg    = ffg;
      eng_bg    = fbg;
      case (state)
         IDLE: begin
            if (cmd_start) begin
               x_nxt = 6'd0;
               y_nxt = 6'd0;
`ifdef CHARMAP_DMA_SCROLL_EN
               state_nxt = cmd_scroll ? SCR_RD : FILL;
`else
               state_nxt = FILL;
`endif
            end
         end
`ifdef CHARMAP_DMA_SCROLL_EN
         FILL, SCR_FILL: begin
`else
         FILL: begin
`endif
            eng_we = 3'b111;
            if (!stall) begin
               if (row_end && (y == Y_LAST)) begin
                  state_nxt = FIN;
               end else begin
                  x_nxt = x_adv;
                  y_nxt = y_adv;
               end
            end
         end
`ifdef CHARMAP_DMA_SCROLL_EN
         SCR_RD: begin
            eng_addr = {y_src, x};
            if (!stall) state_nxt = SCR_CAP;
         end
         SCR_CAP, SCR_WR: begin
            eng_we = 3'b111;
            // SCR_CAP writes the word being captured, SCR_WR the held copy
            if (state == SCR_CAP) begin
               eng_ch = bus.ram_dout_ch;
               eng_fg = bus.ram_dout_fg;
               eng_bg = bus.ram_dout_bg;
            end else begin
               eng_ch = hold_ch;
               eng_fg = hold_fg;
               eng_bg = hold_bg;
            end
            if (!stall) begin
               x_nxt     = x_adv;
               y_nxt     = y_adv;
               state_nxt = (row_end && (y == Y_SCR_LAST)) ? SCR_FILL : SCR_RD;
            end else if (state == SCR_CAP) begin
               state_nxt = SCR_WR;
            end
         end
`endif
         FIN: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ram_addr   = stall ? bus.cpu_addr : eng_addr;
   assign bus.ram_we     = stall ? bus.cpu_we   : eng_we;
   assign bus.ram_din_ch = stall ? bus.cpu_din  : eng_ch;
   assign bus.ram_din_fg = stall ? bus.cpu_din  : eng_fg;
   assign bus.ram_din_bg = stall ? bus.cpu_din  : eng_bg;
endmodule

// File: tb/tb_charmap_dma.sv
// tb_charmap_dma: directed bench for charmap_dma with a RAM model and a write scoreboard.
// Scroll tests run when CHARMAP_DMA_SCROLL_EN is defined; otherwise scroll commands must fill.
module tb_charmap_dma;
   localparam int COLS = 4;
   localparam int ROWS = 2;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  ch;
      logic [7:0]  fg;
      logic [7:0]  bg;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_start, cmd_scroll;
   logic [7:0] fill_ch, fill_fg, fill_bg;
   logic       busy, done;

   int  n_tests = 0;
   int  n_fails = 0;
   int  cycle_cnt = 0;
   int  start_cyc = 0;
   int  n_reads = 0;
   int  lat;
   bit  mon_en = 1'b0;
   wr_t exp_q[$];
   wr_t e;

   logic [7:0] mem_ch [0:4095];
   logic [7:0] mem_fg [0:4095];
   logic [7:0] mem_bg [0:4095];

   charmap_dma_if bus ();

   charmap_dma #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_start  (cmd_start),
      .cmd_scroll (cmd_scroll),
      .fill_ch    (fill_ch),
      .fill_fg    (fill_fg),
      .fill_bg    (fill_bg),
      .busy       (busy),
      .done       (done),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // RAM model, 1-cycle read latency
   always @(posedge clk) begin
      if (bus.ram_we[0]) mem_ch[bus.ram_addr] <= bus.ram_din_ch;
      if (bus.ram_we[1]) mem_fg[bus.ram_addr] <= bus.ram_din_fg;
      if (bus.ram_we[2]) mem_bg[bus.ram_addr] <= bus.ram_din_bg;
      bus.ram_dout_ch <= mem_ch[bus.ram_addr];
      bus.ram_dout_fg <= mem_fg[bus.ram_addr];
      bus.ram_dout_bg <= mem_bg[bus.ram_addr];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.cpu_req === 1'b1) begin
            chk("cpu_addr_pass", 64'(bus.ram_addr), 64'(bus.cpu_addr));
            chk("cpu_we_pass", 64'(bus.ram_we), 64'(bus.cpu_we));
            chk("cpu_din_pass", 64'({bus.ram_din_ch, bus.ram_din_fg, bus.ram_din_bg}),
                64'({3{bus.cpu_din}}));
         end else if (bus.ram_we !== 3'b000) begin
            chk("eng_we", 64'(bus.ram_we), 64'(3'b111));
            chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("eng_write", 64'({bus.ram_addr, bus.ram_din_ch, bus.ram_din_fg, bus.ram_din_bg}),
                   64'(e));
            end
         end else if (busy === 1'b1) begin
            n_reads++;
         end
      end
   end

   task automatic push_fill(input logic [7:0] ch, input logic [7:0] fg, input logic [7:0] bg,
                            input int y_from);
      wr_t w;
      for (int y = y_from; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            w.addr = {6'(y), 6'(x)};
            w.ch = ch; w.fg = fg; w.bg = bg;
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic push_row(input int y, input logic [7:0] base);
      wr_t w;
      for (int x = 0; x < COLS; x++) begin
         w.addr = {6'(y), 6'(x)};
         w.ch = base + 8'(x); w.fg = base + 8'(x); w.bg = base + 8'(x);
         exp_q.push_back(w);
      end
   endtask

   task automatic cpu_row(input int y, input logic [7:0] base);
      for (int x = 0; x < COLS; x++) begin
         @(posedge clk); #1;
         bus.cpu_req = 1'b1; bus.cpu_we = 3'b111;
         bus.cpu_addr = {6'(y), 6'(x)}; bus.cpu_din = base + 8'(x);
      end
      @(posedge clk); #1;
      bus.cpu_req = 1'b0; bus.cpu_we = 3'b000;
   endtask

   // Leaves the caller 1 time unit into cycle 1 after the start edge
   task automatic start(input logic scr, input logic [7:0] ch, input logic [7:0] fg,
                        input logic [7:0] bg);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_scroll = scr;
      fill_ch = ch; fill_fg = fg; fill_bg = bg;
      @(posedge clk); #1;
      start_cyc = cycle_cnt;
      cmd_start = 1'b0;
      fill_ch = ~ch; fill_fg = ~fg; fill_bg = ~bg;
   endtask

   task automatic wait_done(input int max_cyc, output int l);
      l = -1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            l = cycle_cnt - start_cyc + 1;
            break;
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_start = 1'b0; cmd_scroll = 1'b0;
      fill_ch = 8'h00; fill_fg = 8'h00; fill_bg = 8'h00;
      bus.cpu_req = 1'b0; bus.cpu_we = 3'b000; bus.cpu_addr = 12'h000; bus.cpu_din = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ram_we", 64'(bus.ram_we), 64'd0);
      mon_en = 1'b1;

      // Plain fill, no CPU traffic
      push_fill(8'h20, 8'h07, 8'hC7, 0);
      start(1'b0, 8'h20, 8'h07, 8'hC7);
      @(negedge clk);
      chk("t1_busy_up", 64'(busy), 64'd1);
      wait_done(40, lat);
      chk("t1_done_lat", 64'(lat), 64'd9);
      chk("t1_busy_at_done", 64'(busy), 64'd0);
      chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
      next_cycle();
      @(negedge clk);
      chk("t1_done_one_cycle", 64'(done), 64'd0);
      chk("t1_mem_last", 64'({mem_ch[12'h043], mem_fg[12'h043], mem_bg[12'h043]}), 64'h2007C7);

      // Fill with CPU stealing the port on engine cycles 3 and 4
      push_fill(8'h11, 8'h22, 8'h33, 0);
      start(1'b0, 8'h11, 8'h22, 8'h33);
      next_cycle();
      next_cycle();
      bus.cpu_req = 1'b1; bus.cpu_we = 3'b001; bus.cpu_addr = 12'hFC0; bus.cpu_din = 8'h5A;
      next_cycle();
      next_cycle();
      bus.cpu_req = 1'b0; bus.cpu_we = 3'b000;
      wait_done(40, lat);
      chk("t2_done_lat", 64'(lat), 64'd11);
      chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef CHARMAP_DMA_SCROLL_EN
      // Scroll up: row 1 moves to row 0, last row gets the fill values
      cpu_row(1, 8'h41);
      push_row(0, 8'h41);
      push_fill(8'h20, 8'h1F, 8'h00, ROWS - 1);
      n_reads = 0;
      start(1'b1, 8'h20, 8'h1F, 8'h00);
      wait_done(60, lat);
      chk("t3_done_lat", 64'(lat), 64'd13);
      chk("t3_reads", 64'(n_reads), 64'(COLS));
      chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
      next_cycle();
      @(negedge clk);
      chk("t3_done_once", 64'(done), 64'd0);
      chk("t3_row0_ch", 64'(mem_ch[12'h000]), 64'h41);

      // Scroll with a CPU read landing in the first SCR_CAP cycle
      cpu_row(1, 8'h61);
      push_row(0, 8'h61);
      push_fill(8'h30, 8'h31, 8'h32, ROWS - 1);
      n_reads = 0;
      start(1'b1, 8'h30, 8'h31, 8'h32);
      next_cycle();
      bus.cpu_req = 1'b1; bus.cpu_we = 3'b000; bus.cpu_addr = {6'd1, 6'd3};
      next_cycle();
      bus.cpu_req = 1'b0;
      wait_done(60, lat);
      chk("t4_done_lat", 64'(lat), 64'd14);
      chk("t4_no_reread", 64'(n_reads), 64'(COLS));
      chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
`else
      // Without scroll support a scroll command is a plain fill
      push_fill(8'h41, 8'h42, 8'h43, 0);
      n_reads = 0;
      start(1'b1, 8'h41, 8'h42, 8'h43);
      wait_done(40, lat);
      chk("t3_scroll_is_fill_lat", 64'(lat), 64'd9);
      chk("t3_no_reads", 64'(n_reads), 64'd0);
      chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

      // cmd_start while busy and during FIN is ignored
      push_fill(8'h55, 8'h66, 8'h77, 0);
      start(1'b0, 8'h55, 8'h66, 8'h77);
      next_cycle();
      cmd_start = 1'b1; cmd_scroll = 1'b1;
      fill_ch = 8'hAA; fill_fg = 8'hBB; fill_bg = 8'hCC;
      next_cycle();
      cmd_start = 1'b0;
      wait_done(40, lat);
      chk("t5_done_lat", 64'(lat), 64'd9);
      cmd_start = 1'b1; cmd_scroll = 1'b0;
      fill_ch = 8'hEE; fill_fg = 8'hEE; fill_bg = 8'hEE;
      next_cycle();
      cmd_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_stays_idle", 64'({busy, done}), 64'd0);
      end
      chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-fill, then a fresh fill
      push_fill(8'h12, 8'h34, 8'h56, 0);
      repeat (COLS * ROWS - 3) void'(exp_q.pop_back());
      start(1'b0, 8'h12, 8'h34, 8'h56);
      next_cycle();
      next_cycle();
      next_cycle();
      reset = 1'b1;
      bus.cpu_req = 1'b1; bus.cpu_we = 3'b010; bus.cpu_addr = 12'hFFF; bus.cpu_din = 8'h99;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_busy_after_rst", 64'(busy), 64'd0);
      chk("t6_done_after_rst", 64'(done), 64'd0);
      chk("t6_we_is_cpu", 64'(bus.ram_we), 64'(3'b010));
      next_cycle();
      bus.cpu_req = 1'b0; bus.cpu_we = 3'b000;
      @(negedge clk);
      chk("t6_we_idle", 64'(bus.ram_we), 64'd0);
      chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
      push_fill(8'h01, 8'h02, 8'h03, 0);
      start(1'b0, 8'h01, 8'h02, 8'h03);
      wait_done(40, lat);
      chk("t6_restart_lat", 64'(lat), 64'd9);
      chk("t6_restart_sb", 64'(exp_q.size()), 64'd0);

      next_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end
endmodule
